// File: rtl/sfft_reader_pkg.sv
// Shared state encoding, peak record and magnitude helpers for the SFFT output reader.
package sfft_reader_pkg;

  localparam int SFFT_FREQS  = 16;
  localparam int SFFT_ADDR_W = 5;
  localparam int SFFT_DATA_W = 32;
  localparam int ABS_MAX_W   = 64;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    HOLD,
    DONE
  } reader_state_t;

  typedef struct packed {
    logic [SFFT_ADDR_W-1:0] index;
    logic [SFFT_DATA_W-1:0] ampl;
  } peak_t;

  // Largest positive two's-complement value of a w-bit word; the magnitude
  // that the most-negative input saturates to.
  function automatic logic [ABS_MAX_W-1:0] absSatMax(input int w);
    return (ABS_MAX_W'(1) << (w - 1)) - ABS_MAX_W'(1);
  endfunction

endpackage

// File: rtl/sfft_abs_sat.sv
// Combinational signed-to-magnitude conversion; the most-negative code saturates
// to the largest positive value instead of wrapping back to itself.
module sfft_abs_sat
  import sfft_reader_pkg::*;
#(
  parameter int W = SFFT_DATA_W
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] mag
);

  localparam logic [W-1:0] SAT_MAX  = W'(absSatMax(W));
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    if (din == MOST_NEG) begin
      mag = SAT_MAX;
    end else if (din[W-1]) begin
      mag = -din;
    end else begin
      mag = din;
    end
  end

endmodule

// File: rtl/sfft_output_reader.sv
// Sweeps the SFFT output buffer once per OutputValid rising edge, streams bin magnitudes
// over valid/ready and publishes the frame peak. Optional macro: SFFT_READER_SKIP_DC_EN.
module sfft_output_reader
  import sfft_reader_pkg::*;
#(
  parameter int FREQS    = SFFT_FREQS,
  parameter int ADDR_W   = SFFT_ADDR_W,
  parameter int DATA_W   = SFFT_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              OutputValid,
  input  logic              outputReadError,
  input  logic [DATA_W-1:0] SFFT_OutReal,
  output logic              OutputBeingRead,
  output logic [ADDR_W-1:0] output_address,
  output logic [DATA_W-1:0] bin_data,
  output logic [ADDR_W-1:0] bin_index,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic              bin_last,
  output logic [ADDR_W-1:0] peak_index,
  output logic [DATA_W-1:0] peak_ampl,
  output logic              peak_valid,
  output logic              frame_error
);

`ifdef SFFT_READER_SKIP_DC_EN
  localparam bit SKIP_DC = 1'b1;
`else
  localparam bit SKIP_DC = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FREQS - 1);
  localparam logic [1:0]        LAT_END  = 2'(READ_LAT - 1);

  reader_state_t     state, stateNext;
  logic              ovReg;
  logic [1:0]        latCnt, latCntNext;
  peak_t             runPeak, runPeakNext;
  peak_t             pubPeak, pubPeakNext;
  logic [DATA_W-1:0] absVal;

  logic              beingReadNext, binValidNext, binLastNext, peakValidNext, frameErrorNext;
  logic [ADDR_W-1:0] addrNext, binIndexNext;
  logic [DATA_W-1:0] binDataNext;

  logic abortReq, handshake, frameStart, peakCandidate;

  sfft_abs_sat #(.W(DATA_W)) uAbs (
    .din (SFFT_OutReal),
    .mag (absVal)
  );

  assign abortReq      = outputReadError || !OutputValid;
  assign handshake     = bin_valid && bin_ready;
  assign frameStart    = OutputValid && !ovReg;
  assign peakCandidate = (bin_data > runPeak.ampl) && !(SKIP_DC && bin_index == '0);

  assign peak_index = pubPeak.index;
  assign peak_ampl  = pubPeak.ampl;

  always_comb begin
    stateNext      = state;
    latCntNext     = latCnt;
    runPeakNext    = runPeak;
    pubPeakNext    = pubPeak;
    beingReadNext  = OutputBeingRead;
    addrNext       = output_address;
    binDataNext    = bin_data;
    binIndexNext   = bin_index;
    binValidNext   = bin_valid;
    binLastNext    = bin_last;
    peakValidNext  = 1'b0;
    frameErrorNext = frame_error;

    case (state)
      IDLE: begin
        if (frameStart) begin
          stateNext         = ADDR;
          beingReadNext     = 1'b1;
          addrNext          = '0;
          latCntNext        = '0;
          runPeakNext.index = SKIP_DC ? ADDR_W'(1) : '0;
          runPeakNext.ampl  = '0;
        end
      end
      ADDR: begin
        if (!abortReq) begin
          if (latCnt == LAT_END) begin
            stateNext = CAPT;
          end else begin
            latCntNext = latCnt + 2'd1;
          end
        end
      end
      CAPT: begin
        if (!abortReq) begin
          binDataNext  = absVal;
          binIndexNext = output_address;
          binLastNext  = (output_address == LAST_IDX);
          binValidNext = 1'b1;
          stateNext    = HOLD;
        end
      end
      HOLD: begin
        if (!abortReq && handshake) begin
          binValidNext = 1'b0;
          if (peakCandidate) begin
            runPeakNext.index = bin_index;
            runPeakNext.ampl  = bin_data;
          end
          if (bin_last) begin
            stateNext = DONE;
          end else begin
            addrNext   = output_address + ADDR_W'(1);
            latCntNext = '0;
            stateNext  = ADDR;
          end
        end
      end
      DONE: begin
        pubPeakNext   = runPeak;
        peakValidNext = 1'b1;
        beingReadNext = 1'b0;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // An abort overrides any handshake taken in the same cycle; the partial peak is dropped.
    if (abortReq && (state == ADDR || state == CAPT || state == HOLD)) begin
      frameErrorNext = 1'b1;
      binValidNext   = 1'b0;
      beingReadNext  = 1'b0;
      stateNext      = IDLE;
    end
  end

  // ovReg resets high so a level already present at reset release is not taken as a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      ovReg           <= 1'b1;
      latCnt          <= '0;
      runPeak         <= '0;
      pubPeak         <= '0;
      OutputBeingRead <= 1'b0;
      output_address  <= '0;
      bin_data        <= '0;
      bin_index       <= '0;
      bin_valid       <= 1'b0;
      bin_last        <= 1'b0;
      peak_valid      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state           <= stateNext;
      ovReg           <= OutputValid;
      latCnt          <= latCntNext;
      runPeak         <= runPeakNext;
      pubPeak         <= pubPeakNext;
      OutputBeingRead <= beingReadNext;
      output_address  <= addrNext;
      bin_data        <= binDataNext;
      bin_index       <= binIndexNext;
      bin_valid       <= binValidNext;
      bin_last        <= binLastNext;
      peak_valid      <= peakValidNext;
      frame_error     <= frameErrorNext;
    end
  end

endmodule

// File: tb/tb_sfft_output_reader.sv
// Directed bench for sfft_output_reader: table of whole-frame vectors plus
// hand-written abort and mid-sweep reset sequences.
module tb_sfft_output_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        OutputValid;
  logic        outputReadError;
  logic [31:0] SFFT_OutReal;
  logic        OutputBeingRead;
  logic [4:0]  output_address;
  logic [31:0] bin_data;
  logic [4:0]  bin_index;
  logic        bin_valid;
  logic        bin_ready;
  logic        bin_last;
  logic [4:0]  peak_index;
  logic [31:0] peak_ampl;
  logic        peak_valid;
  logic        frame_error;

  logic [31:0] mem [16];
  int nChecks = 0;
  int nPass   = 0;

`ifdef SFFT_READER_SKIP_DC_EN
  localparam int TIE_IDX  = 9;
  localparam int ZERO_IDX = 1;
`else
  localparam int TIE_IDX  = 0;
  localparam int ZERO_IDX = 0;
`endif

  typedef struct {
    bit          ramp;
    logic [31:0] fill;
    int          i0;
    logic [31:0] v0;
    int          i1;
    logic [31:0] v1;
    bit          bp;
    int          expIdx;
    logic [31:0] expAmpl;
  } vec_t;

  sfft_output_reader dut (
    .clk             (clk),
    .reset           (reset),
    .OutputValid     (OutputValid),
    .outputReadError (outputReadError),
    .SFFT_OutReal    (SFFT_OutReal),
    .OutputBeingRead (OutputBeingRead),
    .output_address  (output_address),
    .bin_data        (bin_data),
    .bin_index       (bin_index),
    .bin_valid       (bin_valid),
    .bin_ready       (bin_ready),
    .bin_last        (bin_last),
    .peak_index      (peak_index),
    .peak_ampl       (peak_ampl),
    .peak_valid      (peak_valid),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  // SFFT buffer model with one cycle of read latency.
  always @(posedge clk) SFFT_OutReal <= mem[output_address[3:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] expAbs(input logic [31:0] v);
    if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
    if (v[31]) return (~v) + 32'd1;
    return v;
  endfunction

  task automatic loadVec(input vec_t v);
    for (int k = 0; k < 16; k++) mem[k] = v.ramp ? 32'(10 * k) : v.fill;
    if (v.i0 >= 0) mem[v.i0] = v.v0;
    if (v.i1 >= 0) mem[v.i1] = v.v1;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " OutputBeingRead"}, OutputBeingRead, 0);
    chk({tag, " output_address"}, output_address, 0);
    chk({tag, " bin_data"}, bin_data, 0);
    chk({tag, " bin_index"}, bin_index, 0);
    chk({tag, " bin_valid"}, bin_valid, 0);
    chk({tag, " bin_last"}, bin_last, 0);
    chk({tag, " peak_index"}, peak_index, 0);
    chk({tag, " peak_ampl"}, peak_ampl, 0);
    chk({tag, " peak_valid"}, peak_valid, 0);
    chk({tag, " frame_error"}, frame_error, 0);
  endtask

  // Full frame from a fresh OutputValid edge; bp selects the 1-0-0-1 ready pattern.
  task automatic runFrame(input string tag, input bit bp, input int expIdx, input logic [31:0] expAmpl);
    int nBins, nPeak, firstValid, rc, tail;
    bit stalled;
    logic [31:0] sData;
    logic [4:0] sIdx;
    logic sLast;
    nBins = 0; nPeak = 0; firstValid = -1; rc = 0; tail = 0; stalled = 0;
    sData = '0; sIdx = '0; sLast = 1'b0;
    @(negedge clk);
    OutputValid = 1'b1;
    bin_ready = 1'b0;
    for (int cyc = 1; cyc < 400 && tail < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, " read lock at start"}, OutputBeingRead, 1);
      if (stalled) begin
        chk({tag, " stall valid"}, bin_valid, 1);
        chk({tag, " stall data"}, bin_data, sData);
        chk({tag, " stall index"}, bin_index, sIdx);
        chk({tag, " stall last"}, bin_last, sLast);
      end
      stalled = 0;
      if (peak_valid) begin
        nPeak++;
        chk({tag, " peak_index"}, peak_index, expIdx);
        chk({tag, " peak_ampl"}, peak_ampl, expAmpl);
        chk({tag, " lock after done"}, OutputBeingRead, 0);
      end
      if (nPeak > 0) tail++;
      if (bin_valid) begin
        if (firstValid < 0) firstValid = cyc;
        bin_ready = (!bp) || (rc % 4 == 0) || (rc % 4 == 3);
        rc++;
        if (bin_ready) begin
          if (nBins < 16) begin
            chk({tag, " bin_index"}, bin_index, nBins);
            chk({tag, " bin_data"}, bin_data, expAbs(mem[nBins]));
            chk({tag, " bin_last"}, bin_last, (nBins == 15));
          end
          nBins++;
        end else begin
          stalled = 1;
          sData = bin_data;
          sIdx = bin_index;
          sLast = bin_last;
        end
      end else begin
        bin_ready = 1'b0;
      end
    end
    OutputValid = 1'b0;
    bin_ready = 1'b0;
    chk({tag, " first bin latency"}, firstValid, 3);
    chk({tag, " bin count"}, nBins, 16);
    chk({tag, " peak pulses"}, nPeak, 1);
  endtask

  task automatic startAndWaitBin(input string tag, input int idx);
    bit ok;
    ok = 0;
    @(negedge clk);
    OutputValid = 1'b1;
    bin_ready = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (bin_valid && bin_index == 5'(idx)) ok = 1;
    end
    chk({tag, " reached bin"}, ok, 1);
  endtask

  task automatic watchIdle(input int n, output int nv, output int nl, output int np);
    nv = 0; nl = 0; np = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bin_valid) nv++;
      if (OutputBeingRead) nl++;
      if (peak_valid) np++;
    end
  endtask

  vec_t vecs [5];
  int nv, nl, np;

  initial begin
    vecs[0] = '{ramp: 1, fill: 0, i0: -1, v0: 0, i1: -1, v1: 0, bp: 0, expIdx: 15, expAmpl: 150};
    vecs[1] = '{ramp: 1, fill: 0, i0: -1, v0: 0, i1: -1, v1: 0, bp: 1, expIdx: 15, expAmpl: 150};
    vecs[2] = '{ramp: 0, fill: 5, i0: 3, v0: 32'hFFFF_FF38, i1: 7, v1: 32'h8000_0000,
                bp: 0, expIdx: 7, expAmpl: 32'h7FFF_FFFF};
    vecs[3] = '{ramp: 0, fill: 1, i0: 0, v0: 500, i1: 9, v1: 500, bp: 1, expIdx: TIE_IDX, expAmpl: 500};
    vecs[4] = '{ramp: 0, fill: 0, i0: -1, v0: 0, i1: -1, v1: 0, bp: 0, expIdx: ZERO_IDX, expAmpl: 0};

    for (int k = 0; k < 16; k++) mem[k] = '0;
    SFFT_OutReal = '0;
    reset = 1'b1;
    OutputValid = 1'b0;
    outputReadError = 1'b0;
    bin_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    watchIdle(4, nv, nl, np);
    chk("idle no lock", nl, 0);

    for (int i = 0; i < 5; i++) begin
      loadVec(vecs[i]);
      runFrame($sformatf("vec%0d", i), vecs[i].bp, vecs[i].expIdx, vecs[i].expAmpl);
      chk($sformatf("vec%0d no error", i), frame_error, 0);
    end

    // Abort by OutputValid dropping while bin 6 is offered.
    loadVec(vecs[0]);
    startAndWaitBin("abortOV", 6);
    OutputValid = 1'b0;
    @(negedge clk);
    chk("abortOV bin_valid", bin_valid, 0);
    chk("abortOV lock", OutputBeingRead, 0);
    chk("abortOV frame_error", frame_error, 1);
    watchIdle(40, nv, nl, np);
    chk("abortOV no peak", np, 0);
    runFrame("afterOV", 0, 15, 150);
    chk("frame_error sticky", frame_error, 1);

    // Abort by read error at bin 2; OutputValid stays high and must not restart.
    startAndWaitBin("abortErr", 2);
    outputReadError = 1'b1;
    @(negedge clk);
    outputReadError = 1'b0;
    chk("abortErr bin_valid", bin_valid, 0);
    chk("abortErr lock", OutputBeingRead, 0);
    chk("abortErr frame_error", frame_error, 1);
    watchIdle(30, nv, nl, np);
    chk("abortErr no restart valid", nv, 0);
    chk("abortErr no restart lock", nl, 0);
    chk("abortErr no peak", np, 0);
    OutputValid = 1'b0;
    runFrame("afterErr", 1, 15, 150);

    // Asynchronous reset in the middle of a sweep.
    startAndWaitBin("rst", 4);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    reset = 1'b0;
    watchIdle(30, nv, nl, np);
    chk("postreset no valid", nv, 0);
    chk("postreset no lock", nl, 0);
    chk("postreset no peak", np, 0);
    OutputValid = 1'b0;
    runFrame("afterReset", 0, 15, 150);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
